// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 size codes,
// FSM states and the byte-enable generator.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      BEAT0,
      BEAT1,
      RESP
   } state_t;

   // Unshifted byte enables for an access size; the caller shifts by addr[1:0].
   function automatic logic [3:0] be_gen(input logic [1:0] size);
      case (size)
         SZ_B:    return 4'b0001;
         SZ_H:    return 4'b0011;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 single-port RAM: synchronous read, per-byte write enables.
// Output holds its last value while en is low.
module dmem_ram #(
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lsu_dmem.sv
// MEM-stage load/store unit in front of dmem_ram. Define LSU_MISALIGN_EN to
// split word-crossing accesses into two RAM beats; otherwise they fault.
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int ADDR_W    = $clog2(DEPTH) + 2,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault
);

   localparam int WA_W = ADDR_W - 2;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              fault_q, fault_d;

   logic              req_mis, req_bad;
   logic [1:0]        off;
   logic              ram_en;
   logic [WA_W-1:0]   ram_addr;
   logic [3:0]        ram_we;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [31:0]       ld_raw, ld_ext;

   assign off = addr_q[1:0];

   always_comb begin
      req_mis = ((req_funct3[1:0] == SZ_H) && (req_addr[1:0] == 2'b11)) ||
                ((req_funct3[1:0] == SZ_W) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_EN
      req_bad = (req_funct3[1:0] == 2'b11);
`else
      req_bad = (req_funct3[1:0] == 2'b11) || req_mis;
`endif
   end

`ifdef LSU_MISALIGN_EN
   logic        split_q, split_d;
   logic [31:0] beat0_q, beat0_d;
   logic [63:0] st_lane, ld_pair;
   logic [7:0]  be8;

   // Stores and loads see a 64-bit window {word+1, word}; beat 1 owns the top half.
   always_comb begin
      st_lane   = {32'b0, wdata_q} << {off, 3'b000};
      be8       = {4'b0000, be_gen(f3_q[1:0])} << off;
      ram_addr  = (state_q == BEAT1) ? addr_q[ADDR_W-1:2] + WA_W'(1) : addr_q[ADDR_W-1:2];
      ram_wdata = (state_q == BEAT1) ? st_lane[63:32] : st_lane[31:0];
      ram_we    = '0;
      if (we_q && (state_q == BEAT0)) ram_we = be8[3:0];
      if (we_q && (state_q == BEAT1)) ram_we = be8[7:4];
      ld_pair   = split_q ? {ram_rdata, beat0_q} : {32'b0, ram_rdata};
      ld_raw    = 32'(ld_pair >> {off, 3'b000});
   end
`else
   always_comb begin
      ram_addr  = addr_q[ADDR_W-1:2];
      ram_wdata = wdata_q << {off, 3'b000};
      ram_we    = (we_q && (state_q == BEAT0)) ? (be_gen(f3_q[1:0]) << off) : 4'b0000;
      ld_raw    = ram_rdata >> {off, 3'b000};
   end
`endif

   assign ram_en = (state_q == BEAT0) || (state_q == BEAT1);

   always_comb begin
      case (f3_q[1:0])
         SZ_B:    ld_ext = {{24{ld_raw[7]  & ~f3_q[2]}}, ld_raw[7:0]};
         SZ_H:    ld_ext = {{16{ld_raw[15] & ~f3_q[2]}}, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fault_d = fault_q;
`ifdef LSU_MISALIGN_EN
      split_d = split_q;
      beat0_d = beat0_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               fault_d = req_bad;
`ifdef LSU_MISALIGN_EN
               split_d = req_mis;
`endif
               state_d = req_bad ? RESP : BEAT0;
            end
         end
`ifdef LSU_MISALIGN_EN
         BEAT0: state_d = split_q ? BEAT1 : RESP;
         // Beat-0 read data is on the RAM output now; park it before beat 1 overwrites it.
         BEAT1: begin
            beat0_d = ram_rdata;
            state_d = RESP;
         end
`else
         BEAT0: state_d = RESP;
`endif
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
`ifdef LSU_MISALIGN_EN
         split_q <= 1'b0;
         beat0_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fault_q <= fault_d;
`ifdef LSU_MISALIGN_EN
         split_q <= split_d;
         beat0_q <= beat0_d;
`endif
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_fault = resp_valid && fault_q;
   // RAM is idle in RESP, so its output and hence resp_rdata stay stable under backpressure.
   assign resp_rdata = (resp_valid && !fault_q && !we_q) ? ld_ext : '0;

   dmem_ram #(
      .DEPTH     (DEPTH),
      .AW        (WA_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
